div241_seq_divider: RTL and testbench

//  Sequential radix-256 constant divider: accepts a 36-bit unsigned dividend, returns quotient and remainder of division by 241.

---
 rtl/div241_seq_divider_if.sv | 25 ++
 rtl/div241_seq_divider.sv | 98 +++++++++
 tb/tb_div241_seq_divider.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/div241_seq_divider_if.sv
// Handshake bundle for the sequential constant divider: dividend in, quotient/remainder out.
// Handshake rule (both sides): a transfer happens on a rising edge where valid and ready are both high.
interface div241_seq_divider_if #(
    parameter int WIDTH = 36,
    parameter int DIGIT = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quo;
    logic [DIGIT-1:0] rem;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, quo, rem, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, quo, rem, busy
    );
endinterface

// File: rtl/div241_seq_divider.sv
// Sequential radix-2**DIGIT divider by a constant: one digit per cycle, MSB digit first.
// Each step divides (r*2**DIGIT + d) by DIVISOR; the step quotient always fits in one digit.
module div241_seq_divider #(
    parameter int WIDTH   = 36,
    parameter int DIGIT   = 8,
    parameter int DIVISOR = 241
) (
    input  logic                   clk,
    input  logic                   rst,
    div241_seq_divider_if.slave    bus,
    output logic [1:0]             o_dbg_state
);
    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int DW   = NDIG * DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]      LAST_CNT = CW'(NDIG - 1);
    localparam logic [2*DIGIT-1:0] DIV_C    = (2*DIGIT)'(DIVISOR);

    generate
        if (DIVISOR < 2 || DIVISOR >= (1 << DIGIT) || WIDTH <= DIGIT) begin : g_bad_params
            $error("div241_seq_divider: need 2 <= DIVISOR < 2**DIGIT and WIDTH > DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [DW-1:0]      r_dig;
    logic [DIGIT-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [2*DIGIT-1:0] w_t;
    logic [DIGIT-1:0]   w_qd;
    logic [DIGIT-1:0]   w_rd;

    // Partial remainder is always < DIVISOR, so w_t < DIVISOR*2**DIGIT and the quotient fits a digit.
    assign w_t  = {r_rem, r_dig[DW-1 -: DIGIT]};
    assign w_qd = DIGIT'(w_t / DIV_C);
    assign w_rd = DIGIT'(w_t % DIV_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)        w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST_CNT)   w_next = S_DONE;
            S_DONE:  if (bus.out_ready)       w_next = S_IDLE;
            default:                          w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_dig <= '0;
            r_rem <= '0;
            r_quo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_dig <= DW'(bus.in_data);
                        r_rem <= '0;
                        r_quo <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rd;
                    r_quo <= {r_quo[WIDTH-DIGIT-1:0], w_qd};
                    r_dig <= {r_dig[DW-DIGIT-1:0], DIGIT'(0)};
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // All outputs are decodes of registers only.
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.quo       = r_quo;
    assign bus.rem       = r_rem;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_div241_seq_divider.sv
// Bench for div241_seq_divider: directed vector table, multi-cycle corner sequences and a
// randomized in-order stream checked against plain division by 241.
module tb_div241_seq_divider;
    localparam int W = 36;
    localparam int N_RAND = 2000;

    logic clk;
    logic rst;
    logic [1:0] dbg_state;

    int n_checks;
    int n_err;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] q;
        logic [7:0]   r;
    } vec_t;

    vec_t vecs[6];

    div241_seq_divider_if #(.WIDTH(W), .DIGIT(8)) bus ();

    div241_seq_divider #(.WIDTH(W), .DIGIT(8), .DIVISOR(241)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Offer one dividend, wait for out_valid, verify latency and RUN-phase flags.
    task automatic start_and_wait(input string tag, input logic [W-1:0] din, output bit seen);
        int w;
        int lat;
        w = 0;
        seen = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = W'({$urandom(), $urandom()});
        lat = 0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) seen = 1;
            check({tag, "_busy_noready"}, {62'd0, bus.in_ready, bus.busy}, 64'd1);
        end
        check({tag, "_latency"}, 64'(lat), 64'd5);
    endtask

    task automatic retire(input string tag, input logic [W-1:0] eq, input logic [7:0] er);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_retired_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_retired_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_idle_quo_kept"}, 64'(bus.quo), 64'(eq));
        check({tag, "_idle_rem_kept"}, 64'(bus.rem), 64'(er));
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] din, input logic [W-1:0] eq,
                           input logic [7:0] er);
        bit seen;
        start_and_wait(tag, din, seen);
        check({tag, "_quo"}, 64'(bus.quo), 64'(eq));
        check({tag, "_rem"}, 64'(bus.rem), 64'(er));
        retire(tag, eq, er);
    endtask

    initial begin
        bit seen;
        logic [W-1:0] q_hold;
        logic [7:0]   r_hold;
        logic [W-1:0] din;
        int sent;
        int got;
        int cyc;

        n_checks = 0;
        n_err    = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{din: 36'd0,           q: 36'd0,         r: 8'd0};
        vecs[1] = '{din: 36'd241,         q: 36'd1,         r: 8'd0};
        vecs[2] = '{din: 36'd240,         q: 36'd0,         r: 8'd240};
        vecs[3] = '{din: 36'd1000,        q: 36'd4,         r: 8'd36};
        vecs[4] = '{din: 36'd68719476735, q: 36'd285143056, r: 8'd239};
        vecs[5] = '{din: 36'd58081,       q: 36'd241,       r: 8'd0};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_quo",       64'(bus.quo),       64'd0);
        check("rst_rem",       64'(bus.rem),       64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].din, vecs[i].q, vecs[i].r);
        end

        // Backpressure: result held for 10 cycles while in_valid pulses are ignored
        start_and_wait("bp", 36'd123456789, seen);
        q_hold = 36'd512268;
        r_hold = 8'd201;
        check("bp_quo", 64'(bus.quo), 64'(q_hold));
        check("bp_rem", 64'(bus.rem), 64'(r_hold));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = W'({$urandom(), $urandom()});
            @(posedge clk);
            #1;
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_quo",   64'(bus.quo),       64'(q_hold));
            check("bp_hold_rem",   64'(bus.rem),       64'(r_hold));
            check("bp_hold_ready", 64'(bus.in_ready),  64'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        retire("bp", q_hold, r_hold);

        // Reset during the third RUN cycle aborts the division
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 36'd68719476735;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_quo",       64'(bus.quo),       64'd0);
        check("abort_rem",       64'(bus.rem),       64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready",  64'(bus.in_ready),  64'd1);
        check("abort_busy",      64'(bus.busy),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("after_abort", 36'd482, 36'd2, 8'd0);

        // Randomized back-to-back stream with random consumer stalls
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < N_RAND && cyc < N_RAND * 40) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_result", 64'(exp_q.size()), 64'd1);
                end else begin
                    din = exp_q.pop_front();
                    check("rand_quo", 64'(bus.quo), 64'(din / 36'd241));
                    check("rand_rem", 64'(bus.rem), 64'(din % 36'd241));
                end
                got++;
            end
            if (sent < N_RAND) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0:       bus.in_data = 36'hF_FFFF_FFFF;
                    1:       bus.in_data = W'($urandom_range(0, 600));
                    default: bus.in_data = W'({$urandom(), $urandom()});
                endcase
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(bus.in_data);
                    sent++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        check("rand_all_results", 64'(got), 64'(N_RAND));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("rand_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
